// File: rtl/seq_mult.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : seq_mult                                                   |
// | Description : Sequential radix-2 shift-add multiplier with valid/ready   |
// |               handshakes and per-transaction signed/unsigned mode.       |
// |               Takes WIDTH steps per product, one step per clock.         |
// | Ports       : clk, rst (async, active-high)                              |
// |               in_valid/in_ready  - operand handshake (a, b, signed_mode) |
// |               out_valid/out_ready - product handshake (y, 2*WIDTH bits)  |
// |               busy               - high while in CALC or DONE            |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module seq_mult #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               signed_mode,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] y,
  output logic               busy
);

  localparam logic [1:0]       c_idle = 2'd0;
  localparam logic [1:0]       c_calc = 2'd1;
  localparam logic [1:0]       c_done = 2'd2;
  localparam logic [CNT_W-1:0] c_last = CNT_W'(WIDTH - 1);

  logic [1:0]         r_state;
  logic [1:0]         w_next_state;
  logic [CNT_W-1:0]   r_cnt;
  // Upper half: running partial product. Lower half: remaining multiplier
  // bits, consumed LSB-first as the whole register shifts right.
  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH-1:0]   r_mcand;
  logic               r_neg;
  logic [2*WIDTH-1:0] r_y;

  logic [WIDTH-1:0]   w_a_mag;
  logic [WIDTH-1:0]   w_b_mag;
  logic [WIDTH-1:0]   w_addend;
  logic [WIDTH:0]     w_sum;
  logic [2*WIDTH-1:0] w_acc_next;
  logic [2*WIDTH-1:0] w_y_next;
  logic               w_last;
  logic               w_accept;

  // Magnitudes: -2^(W-1) negates to itself, which reads correctly as the
  // unsigned value 2^(W-1), so no extra bit is needed.
  assign w_a_mag = (signed_mode && a[WIDTH-1]) ? -a : a;
  assign w_b_mag = (signed_mode && b[WIDTH-1]) ? -b : b;

  assign w_addend   = r_acc[0] ? r_mcand : '0;
  // The carry out of the add becomes the MSB after the right shift.
  assign w_sum      = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, w_addend};
  assign w_acc_next = {w_sum, r_acc[WIDTH-1:1]};
  assign w_y_next   = r_neg ? -w_acc_next : w_acc_next;
  assign w_last     = (r_cnt == c_last);
  assign w_accept   = in_valid && (r_state == c_idle);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= c_idle;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      c_idle: if (in_valid)  w_next_state = c_calc;
      c_calc: if (w_last)    w_next_state = c_done;
      c_done: if (out_ready) w_next_state = c_idle;
      default:               w_next_state = c_idle;
    endcase
  end

  // Output logic
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (r_state)
      c_idle: in_ready = 1'b1;
      c_calc: busy     = 1'b1;
      c_done: begin
        out_valid = 1'b1;
        busy      = 1'b1;
      end
      default: in_ready = 1'b0;
    endcase
  end

  // Datapath
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt   <= '0;
      r_acc   <= '0;
      r_mcand <= '0;
      r_neg   <= 1'b0;
      r_y     <= '0;
    end else begin
      if (w_accept) begin
        r_mcand <= w_a_mag;
        r_acc   <= {{WIDTH{1'b0}}, w_b_mag};
        r_cnt   <= '0;
        r_neg   <= signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
      end else if (r_state == c_calc) begin
        r_acc <= w_acc_next;
        r_cnt <= r_cnt + 1'b1;
        if (w_last) begin
          r_y <= w_y_next;
        end
      end
    end
  end

  assign y = r_y;

endmodule
`default_nettype wire
